// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one single-port memory.
// Data wins by default; fetch is forced after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        owner,
    output logic        busy,
    output logic        err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);

    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [WW-1:0] r_wdog;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_owner;
    logic          r_busy;
    logic          r_err;
    logic          r_if_ready;
    logic          r_dm_ready;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;

    logic          w_starved;
    logic          w_grant_dm;
    logic          w_grant_if;
    logic          w_timeout;
    logic          w_finish;
    logic [31:0]   w_rdata;
    logic [SW-1:0] w_streak_inc;

    assign w_starved  = (r_streak == STREAK_MAX);
    assign w_grant_dm = dm_req && (!if_req || !w_starved);
    assign w_grant_if = if_req && !w_grant_dm;

    // An ack on the last watchdog cycle takes precedence over the timeout.
    assign w_timeout  = (r_wdog == WD_LAST);
    assign w_finish   = mem_ack || w_timeout;
    assign w_rdata    = mem_ack ? mem_rdata : ERR_DATA;

    assign w_streak_inc = w_starved ? r_streak
                                    : r_streak + SW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_dm) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_owner     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_wdog      <= '0;
                        r_streak    <= if_req ? w_streak_inc : '0;
                        r_state     <= S_WAIT;
                    end else if (w_grant_if) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_owner     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_wdog      <= '0;
                        r_streak    <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_finish) begin
                        r_mem_req  <= 1'b0;
                        r_if_ready <= !r_owner;
                        r_dm_ready <= r_owner;
                        r_state    <= S_RESP;
                        if (!mem_ack) begin
                            r_err <= 1'b1;
                        end
                        if (!r_mem_we && r_owner) begin
                            r_dm_rdata <= w_rdata;
                        end
                        if (!r_mem_we && !r_owner) begin
                            r_if_rdata <= w_rdata;
                        end
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, write/read, contention,
// timeout, boundary ack and reset during an access.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        owner;
    logic        busy;
    logic        err;

    int n_chk;
    int n_fail;
    logic [31:0] model_mem [bit [31:0]];

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (16),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .owner    (owner),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // Backing memory: acks the access currently presented on mem_*.
    task automatic mem_respond();
        mem_ack = 1'b1;
        if (mem_we) begin
            model_mem[mem_addr] = mem_wdata;
            mem_rdata = 32'h0;
        end else if (model_mem.exists(mem_addr)) begin
            mem_rdata = model_mem[mem_addr];
        end else begin
            mem_rdata = 32'h0;
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_dm_ready", 32'(dm_ready), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        reset = 1'b1;
        tick();

        // single fetch
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h40);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_owner", 32'(owner), 0);
        chk("f_busy", 32'(busy), 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2008000F;
        tick();
        chk("f_if_ready", 32'(if_ready), 1);
        chk("f_dm_ready", 32'(dm_ready), 0);
        chk("f_if_rdata", if_rdata, 32'h2008000F);
        chk("f_mem_req_drop", 32'(mem_req), 0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        chk("f_ready_pulse", 32'(if_ready), 0);
        chk("f_idle_busy", 32'(busy), 0);
        chk("f_rdata_hold", if_rdata, 32'h2008000F);

        // dm write then read
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h54;
        dm_wdata = 32'd100;
        tick();
        chk("w_mem_we", 32'(mem_we), 1);
        chk("w_mem_wdata", mem_wdata, 32'd100);
        chk("w_mem_addr", mem_addr, 32'h54);
        chk("w_owner", 32'(owner), 1);
        mem_respond();
        tick();
        chk("w_dm_ready", 32'(dm_ready), 1);
        chk("w_if_ready", 32'(if_ready), 0);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        tick();
        chk("w_ready_pulse", 32'(dm_ready), 0);
        chk("w_rdata_untouched", dm_rdata, 0);
        dm_req = 1'b1;
        dm_we  = 1'b0;
        tick();
        chk("r_mem_we", 32'(mem_we), 0);
        chk("r_mem_addr", mem_addr, 32'h54);
        mem_respond();
        tick();
        chk("r_dm_ready", 32'(dm_ready), 1);
        chk("r_dm_rdata", dm_rdata, 32'd100);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        tick();
        chk("r_ready_pulse", 32'(dm_ready), 0);

        // contention: data wins four times, then fetch
        if_req  = 1'b1;
        if_addr = 32'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("c_owner%0d", i), 32'(owner),
                (i % 5 == 4) ? 0 : 1);
            mem_respond();
            tick();
            chk($sformatf("c_if_rdy%0d", i), 32'(if_ready),
                (i % 5 == 4) ? 1 : 0);
            chk($sformatf("c_dm_rdy%0d", i), 32'(dm_ready),
                (i % 5 == 4) ? 0 : 1);
            mem_ack = 1'b0;
            tick();
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();

        // timeout on a dm read
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        tick();
        chk("t_req_0", 32'(mem_req), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("t_req_%0d", i), 32'(mem_req), 1);
        end
        chk("t_no_err_yet", 32'(err), 0);
        tick();
        chk("t_req_drop", 32'(mem_req), 0);
        chk("t_dm_ready", 32'(dm_ready), 1);
        chk("t_dm_rdata", dm_rdata, 32'hDEADBEEF);
        chk("t_err", 32'(err), 1);
        dm_req = 1'b0;
        tick();
        chk("t_ready_pulse", 32'(dm_ready), 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        chk("t_late_busy", 32'(busy), 0);
        chk("t_late_ready", 32'(dm_ready), 0);
        chk("t_late_rdata", dm_rdata, 32'hDEADBEEF);
        chk("t_err_sticky", 32'(err), 1);
        mem_ack = 1'b0;
        tick();
        chk("t_err_sticky2", 32'(err), 1);

        // clear err, then ack exactly on the last watchdog cycle
        reset = 1'b0;
        tick();
        chk("b_err_clr", 32'(err), 0);
        reset   = 1'b1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h54;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        chk("b_still_wait", 32'(mem_req), 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("b_dm_ready", 32'(dm_ready), 1);
        chk("b_dm_rdata", dm_rdata, 32'h1234_5678);
        chk("b_err", 32'(err), 0);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        tick();
        chk("b_err_after", 32'(err), 0);

        // reset while waiting for ack
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick();
        chk("x_wait", 32'(busy), 1);
        tick();
        reset  = 1'b0;
        if_req = 1'b0;
        tick();
        chk("x_mem_req", 32'(mem_req), 0);
        chk("x_busy", 32'(busy), 0);
        chk("x_if_ready", 32'(if_ready), 0);
        chk("x_dm_ready", 32'(dm_ready), 0);
        chk("x_err", 32'(err), 0);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        chk("x_late_ready", 32'(if_ready), 0);
        chk("x_late_busy", 32'(busy), 0);
        mem_ack = 1'b0;
        tick();
        chk("x_late_ready2", 32'(if_ready), 0);
        chk("x_rdata", if_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (read-only port "if") and the memory stage (read/write port "dm") of the 5-stage pipeline.
- Serialises accesses and runs the request/acknowledge handshake to the memory.
- Drops ready while an access is pending; the hazard logic uses that to stall the affected stages.
- Applies fixed data-over-fetch priority with a starvation limit, and a watchdog on the memory acknowledge.

Parameters:
- STARVE_LIMIT, 4, consecutive dm grants allowed while if_req is pending before fetch is forced (>=1).
- TIMEOUT, 16, cycles to wait for mem_ack before aborting the access (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- if_req  in  1  fetch read request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetch read data; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_rdata  out  32  data read data; valid while dm_ready=1 after a read.
- dm_ready  out  1  one-cycle completion pulse for the data port.
- mem_req  out  1  memory request, registered; held until mem_ack or timeout.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_rdata  in  32  memory read data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge from memory.
- owner  out  1  0=fetch, 1=data; meaningful while busy=1.
- busy  out  1  1 in any state other than IDLE.
- err  out  1  sticky: set on any timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state=IDLE; streak=0; watchdog=0.
- States:
  - IDLE: sample requests. If none, stay.
  - On a grant: latch the winner's addr/we/wdata into the mem_* registers, set mem_req=1, set owner, go to WAIT.
  - Fetch grants always have mem_we=0 and mem_wdata=0.
  - WAIT, on mem_ack=1: clear mem_req; for a read, capture mem_rdata into the owner's rdata register; go to RESP.
  - WAIT, when watchdog==TIMEOUT-1 with no ack: clear mem_req; set err; load ERR_DATA into the owner's rdata if the access is a read; go to RESP.
  - RESP: pulse the owner's ready for exactly one cycle, then go to IDLE. Request inputs are ignored in RESP.
- Arbitration in IDLE:
  - Only dm_req: grant dm. Only if_req: grant if.
  - Both requesting: grant dm unless streak==STARVE_LIMIT, in which case grant if.
  - streak increments on a dm grant while if_req=1 (saturating at STARVE_LIMIT).
  - streak clears on any if grant, and on a dm grant while if_req=0.
- Latency: request seen in IDLE at cycle N -> mem_req=1 from N+1.
  - Ack at cycle N+k (k>=1) -> ready=1 at N+k+1 -> IDLE at N+k+2.
  - Minimum 3 cycles request-to-ready.
  - A requester holding req through its ready cycle is re-arbitrated as a new access in the following IDLE cycle.
- Watchdog: counts WAIT cycles starting at 0. A mem_ack in the same cycle the count reaches TIMEOUT-1 wins; no error is raised.
- rdata registers hold their last value when not updated. dm_rdata is not updated on writes.
- mem_ack outside WAIT (stray, or late after a timeout) is ignored with no state change.
- Reset mid-access: immediate return to reset values. The in-flight access is abandoned; its late ack is ignored.
- if_ready and dm_ready are never both 1 in the same cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40, memory acks 1 cycle after mem_req with 0x2008000F -> mem_addr=0x40, mem_we=0; if_ready pulses 3 cycles after the request with if_rdata=0x2008000F.
- Write then read: dm write addr=0x54 data=100, then dm read 0x54 from a backing model -> mem_we=1 with mem_wdata=100 on the first access; the second access returns dm_rdata=100; each dm_ready lasts 1 cycle.
- Contention: if_req and dm_req both held continuously, STARVE_LIMIT=4 -> grant order dm,dm,dm,dm,if,dm,... and no fetch wait exceeds 4 dm accesses.
- Timeout: dm read, mem_ack never arrives, TIMEOUT=16 -> mem_req drops after 16 WAIT cycles; dm_ready pulses with dm_rdata=0xDEADBEEF; err=1 and stays 1. An ack arriving 2 cycles later is ignored.
- Boundary ack: mem_ack arrives exactly on WAIT cycle 16 (count 15) -> normal completion with memory data; err stays 0.
- Reset mid-access: reset=0 for one posedge while in WAIT -> next cycle mem_req=0, busy=0, ready outputs 0, err=0; a subsequent mem_ack causes no ready pulse.
